// File: rtl/axi4s_downsizer_pkg.sv
// Shared types and helpers for the AXI4-Stream width downsizer.
package axi4s_downsizer_pkg;

    localparam int unsigned PAR_GRAN = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } head_st_t;

    // Even parity over one 16-bit TUSER granule
    function automatic logic calc_parity(input logic [PAR_GRAN-1:0] word);
        return ^word;
    endfunction

    function automatic int unsigned calc_ratio(input int unsigned src_dw, input int unsigned dst_dw);
        return src_dw / dst_dw;
    endfunction

    // Chunk index width, never below one bit so RATIO=1 still has a legal index
    function automatic int unsigned calc_idx_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with per-16-bit parity carried on TUSER.
interface axi4_stream_if #(
    parameter int unsigned DW     = 64,
    parameter int unsigned ID_W   = 4,
    parameter int unsigned DEST_W = 4,
    parameter int unsigned USER_W = DW / 16
) ();
    logic              tvalid;
    logic              tready;
    logic [DW-1:0]     tdata;
    logic [DW/8-1:0]   tkeep;
    logic [DW/8-1:0]   tstrb;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
    modport dst (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axi4s_chunk_sel.sv
// Find-first-set over the chunk mask starting at from_idx (inclusive).
module axi4s_chunk_sel #(
    parameter int unsigned RATIO = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [RATIO-1:0] mask,
    input  logic [IDX_W-1:0] from_idx,
    output logic [IDX_W-1:0] cur_idx_c,
    output logic             is_last_c,
    output logic             none_left_c
);

    // Lowest populated chunk at or above from_idx, and whether any populated chunk lies beyond it
    always_comb begin
        cur_idx_c   = '0;
        none_left_c = 1'b1;
        is_last_c   = 1'b1;
        for (int i = int'(RATIO) - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from_idx))) begin
                cur_idx_c   = IDX_W'(i);
                none_left_c = 1'b0;
            end
        end
        for (int i = 0; i < int'(RATIO); i++) begin
            if (mask[i] && (i > int'(cur_idx_c))) begin
                is_last_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi4s_downsizer_p.sv
// AXI4-Stream SRC_DW -> DST_DW downsizer: 2-deep beat buffer, null-chunk skipping, parity check/regen.
module axi4s_downsizer_p
    import axi4s_downsizer_pkg::*;
#(
    parameter int unsigned SRC_DW    = 256,
    parameter int unsigned DST_DW    = 64,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned DEST_W    = 4,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axi4_stream_if.dst           axis_in,
    axi4_stream_if.src           axis_out,
    output logic                 parity_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned RATIO  = calc_ratio(SRC_DW, DST_DW);
    localparam int unsigned IDX_W  = calc_idx_w(RATIO);
    localparam int unsigned SRC_B  = SRC_DW / 8;
    localparam int unsigned DST_B  = DST_DW / 8;
    localparam int unsigned SRC_PW = SRC_DW / PAR_GRAN;
    localparam int unsigned DST_PW = DST_DW / PAR_GRAN;

    if ((SRC_DW % DST_DW) != 0) begin : g_bad_ratio
        $error("axi4s_downsizer_p: SRC_DW must be an integer multiple of DST_DW");
    end
    if ((DST_DW % PAR_GRAN) != 0) begin : g_bad_dst
        $error("axi4s_downsizer_p: DST_DW must be a multiple of 16");
    end

    logic [SRC_DW-1:0] mem_data  [2];
    logic [SRC_B-1:0]  mem_keep  [2];
    logic [SRC_B-1:0]  mem_strb  [2];
    logic              mem_last  [2];
    logic [ID_W-1:0]   mem_id    [2];
    logic [DEST_W-1:0] mem_dest  [2];

    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_nxt_c;
    head_st_t   st_q;
    logic [IDX_W-1:0] idx_q;

    logic             push_c, pop_c, fire_c, final_c, out_valid_c;
    logic [RATIO-1:0] mask_c;
    logic [IDX_W-1:0] cur_idx_c, sel_c;
    logic             is_last_c, none_left_c;
    logic [SRC_PW-1:0] in_par_c;
    logic              par_bad_c;

    logic [DST_DW-1:0] out_data_c;
    logic [DST_B-1:0]  out_keep_c, out_strb_c;
    logic              out_last_c;
    logic [ID_W-1:0]   out_id_c;
    logic [DEST_W-1:0] out_dest_c;
    logic [DST_PW-1:0] out_user_c;

    assign axis_in.tready = (count_q != 2'd2) && !rst;
    assign push_c         = axis_in.tvalid && axis_in.tready;

    // Beat storage; contents are only meaningful while counted, so no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data[wr_ptr_q] <= axis_in.tdata;
            mem_keep[wr_ptr_q] <= axis_in.tkeep;
            mem_strb[wr_ptr_q] <= axis_in.tstrb;
            mem_last[wr_ptr_q] <= axis_in.tlast;
            mem_id[wr_ptr_q]   <= axis_in.tid;
            mem_dest[wr_ptr_q] <= axis_in.tdest;
        end
    end

    // Per-chunk occupancy of the head beat
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(RATIO); i++) begin
            mask_c[i] = |mem_keep[rd_ptr_q][i*DST_B +: DST_B];
        end
    end

    axi4s_chunk_sel #(
        .RATIO (RATIO),
        .IDX_W (IDX_W)
    ) u_chunk_sel (
        .mask        (mask_c),
        .from_idx    (idx_q),
        .cur_idx_c   (cur_idx_c),
        .is_last_c   (is_last_c),
        .none_left_c (none_left_c)
    );

    // Output mux from head beat; all-null beats without tlast are dropped, with tlast become one empty chunk
    always_comb begin
        out_data_c  = '0;
        out_keep_c  = '0;
        out_strb_c  = '0;
        out_last_c  = 1'b0;
        out_id_c    = '0;
        out_dest_c  = '0;
        out_user_c  = '0;
        out_valid_c = (st_q == ST_EMIT) && !(none_left_c && !mem_last[rd_ptr_q]);
        sel_c       = none_left_c ? '0 : cur_idx_c;
        final_c     = none_left_c || is_last_c;
        if (out_valid_c) begin
            out_data_c = mem_data[rd_ptr_q][sel_c*DST_DW +: DST_DW];
            if (!none_left_c) begin
                out_keep_c = mem_keep[rd_ptr_q][sel_c*DST_B +: DST_B];
                out_strb_c = mem_strb[rd_ptr_q][sel_c*DST_B +: DST_B];
            end
            out_last_c = mem_last[rd_ptr_q] && final_c;
            out_id_c   = mem_id[rd_ptr_q];
            out_dest_c = mem_dest[rd_ptr_q];
            for (int j = 0; j < int'(DST_PW); j++) begin
                out_user_c[j] = calc_parity(out_data_c[j*PAR_GRAN +: PAR_GRAN]);
            end
        end
        fire_c      = out_valid_c && axis_out.tready;
        pop_c       = (fire_c && final_c) ||
                      ((st_q == ST_EMIT) && none_left_c && !mem_last[rd_ptr_q]);
        count_nxt_c = count_q + 2'(push_c) - 2'(pop_c);
    end

    assign axis_out.tvalid = out_valid_c;
    assign axis_out.tdata  = out_data_c;
    assign axis_out.tkeep  = out_keep_c;
    assign axis_out.tstrb  = out_strb_c;
    assign axis_out.tlast  = out_last_c;
    assign axis_out.tid    = out_id_c;
    assign axis_out.tdest  = out_dest_c;
    assign axis_out.tuser  = out_user_c;

    // Head FSM, FIFO pointers and chunk cursor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            st_q     <= ST_IDLE;
            idx_q    <= '0;
        end else begin
            if (push_c) wr_ptr_q <= ~wr_ptr_q;
            if (pop_c)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_nxt_c;
            st_q    <= (count_nxt_c != 2'd0) ? ST_EMIT : ST_IDLE;
            if (pop_c) begin
                idx_q <= '0;
            end else if (fire_c) begin
                idx_q <= cur_idx_c + IDX_W'(1);
            end
        end
    end

    // Recomputed parity of the incoming beat
    always_comb begin
        in_par_c = '0;
        for (int j = 0; j < int'(SRC_PW); j++) begin
            in_par_c[j] = calc_parity(axis_in.tdata[j*PAR_GRAN +: PAR_GRAN]);
        end
        par_bad_c = push_c && (in_par_c != axis_in.tuser);
    end

    // Parity error pulse and saturating error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
            err_cnt    <= '0;
        end else begin
            parity_err <= par_bad_c;
            if (par_bad_c && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axi4s_downsizer_p.sv
// Bench for axi4s_downsizer_p (256 -> 64): directed cases plus randomized traffic vs a chunk-queue model.
module tb_axi4s_downsizer_p;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic [7:0]  s;
        logic        l;
        logic [3:0]  u;
        logic [3:0]  id;
        logic [3:0]  dest;
    } chunk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        parity_err;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    axi4_stream_if #(.DW(256), .ID_W(4), .DEST_W(4), .USER_W(16)) in_if ();
    axi4_stream_if #(.DW(64),  .ID_W(4), .DEST_W(4), .USER_W(4))  out_if ();

    axi4s_downsizer_p #(
        .SRC_DW(256), .DST_DW(64), .ID_W(4), .DEST_W(4), .ERR_CNT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .axis_in    (in_if),
        .axis_out   (out_if),
        .parity_err (parity_err),
        .err_cnt    (err_cnt)
    );

    int          errors = 0;
    int          checks = 0;
    chunk_t      exp_q[$];
    logic        pe_exp = 1'b0;
    logic [15:0] cnt_exp = '0;
    int          fire_cnt = 0;
    int          cyc = 0;
    bit          log_fires = 1'b0;
    int          fire_cyc[$];
    bit          rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] par16(input logic [255:0] d);
        logic [15:0] p;
        for (int j = 0; j < 16; j++) p[j] = ^d[16*j +: 16];
        return p;
    endfunction

    function automatic logic [3:0] par4(input logic [63:0] d);
        logic [3:0] p;
        for (int j = 0; j < 4; j++) p[j] = ^d[16*j +: 16];
        return p;
    endfunction

    // Reference: each 64-bit lane with any kept byte becomes one chunk, in lane order
    task automatic model_beat(input logic [255:0] d, input logic [31:0] k, input logic [31:0] s,
                              input logic l, input logic [3:0] id, input logic [3:0] dest);
        chunk_t c;
        chunk_t lst[$];
        for (int i = 0; i < 4; i++) begin
            if (k[8*i +: 8] != 8'h00) begin
                c.d = d[64*i +: 64]; c.k = k[8*i +: 8]; c.s = s[8*i +: 8];
                c.l = 1'b0; c.u = par4(c.d); c.id = id; c.dest = dest;
                lst.push_back(c);
            end
        end
        if (lst.size() == 0 && l) begin
            c.d = d[63:0]; c.k = '0; c.s = '0; c.l = 1'b1; c.u = par4(c.d); c.id = id; c.dest = dest;
            lst.push_back(c);
        end else if (lst.size() != 0) begin
            lst[lst.size()-1].l = l;
        end
        foreach (lst[i]) exp_q.push_back(lst[i]);
    endtask

    // Model update at each active edge from pre-edge handshake values
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            pe_exp  = 1'b0;
            cnt_exp = '0;
        end else begin
            pe_exp = 1'b0;
            if (in_if.tvalid && in_if.tready) begin
                model_beat(in_if.tdata, in_if.tkeep, in_if.tstrb, in_if.tlast, in_if.tid, in_if.tdest);
                if (in_if.tuser !== par16(in_if.tdata)) begin
                    pe_exp = 1'b1;
                    if (cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
                end
            end
        end
    end

    // Output monitor on the inactive edge
    always @(negedge clk) begin
        chunk_t got;
        cyc++;
        if (!rst) begin
            chk("parity_err", 128'(parity_err), 128'(pe_exp));
            chk("err_cnt", 128'(err_cnt), 128'(cnt_exp));
            got = {out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast, out_if.tuser, out_if.tid, out_if.tdest};
            if (out_if.tvalid) begin
                if (out_if.tready) begin
                    fire_cnt++;
                    if (log_fires) fire_cyc.push_back(cyc);
                    chk("chunk", 128'(got), (exp_q.size() > 0) ? 128'(exp_q.pop_front()) : {35'd0, {93{1'bx}}});
                end
            end else begin
                chk("idle_zero", 128'(got), 128'd0);
            end
        end
    end

    // Random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_if.tready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [255:0] d, input logic [31:0] k, input logic [31:0] s, input logic l,
                        input logic [3:0] id, input logic [3:0] dest, input bit bad);
        bit acc = 1'b0;
        bit r;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tstrb  = s;
        in_if.tlast  = l;
        in_if.tid    = id;
        in_if.tdest  = dest;
        in_if.tuser  = par16(d) ^ (bad ? 16'h0020 : 16'h0000);
        in_if.tvalid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            r = in_if.tready;
            @(posedge clk);
            acc = r;
            #1;
        end
        in_if.tvalid = 1'b0;
        if (!acc) chk("send_timeout", 128'(acc), 128'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 3000 && exp_q.size() > 0; n++) @(negedge clk);
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [255:0] pat;
        logic [31:0]  k;
        logic [127:0] snap;
        int           f0;

        rst = 1'b1;
        in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tkeep = '0; in_if.tstrb = '0;
        in_if.tlast = 1'b0; in_if.tid = '0; in_if.tdest = '0; in_if.tuser = '0;
        out_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_if.tvalid), 128'd0);
        chk("rst_in_ready", 128'(in_if.tready), 128'd0);
        chk("rst_out_data", 128'(out_if.tdata), 128'd0);
        chk("rst_perr", 128'(parity_err), 128'd0);
        chk("rst_err_cnt", 128'(err_cnt), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 128'(in_if.tready), 128'd1);

        // Case 1: full beat, byte-index pattern, four chunks on consecutive cycles
        out_if.tready = 1'b1;
        for (int i = 0; i < 32; i++) pat[8*i +: 8] = 8'(i);
        f0 = fire_cnt;
        send(pat, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1, 4'h2, 1'b0);
        @(negedge clk);
        chk("t1_latency_valid", 128'(out_if.tvalid), 128'd1);
        chk("t1_chunk0", 128'(out_if.tdata), 128'h0706050403020100);
        repeat (3) @(negedge clk);
        #1;
        chk("t1_four_consecutive", 128'(fire_cnt - f0), 128'd4);
        drain();

        // Case 2: eight back-to-back beats, 32 chunks with no gaps
        fire_cyc.delete();
        log_fires = 1'b1;
        for (int b = 0; b < 8; b++) send(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, b == 7, 4'(b), 4'hA, 1'b0);
        drain();
        log_fires = 1'b0;
        chk("t2_chunk_count", 128'(fire_cyc.size()), 128'd32);
        if (fire_cyc.size() == 32) chk("t2_no_bubble", 128'(fire_cyc[31] - fire_cyc[0]), 128'd31);

        // Case 3: sparse keep patterns
        f0 = fire_cnt;
        send(rnd256(), 32'h0000_FFFF, 32'h0000_FFFF, 1'b1, 4'h3, 4'h4, 1'b0);
        drain();
        chk("t3_low_half_chunks", 128'(fire_cnt - f0), 128'd2);
        f0 = fire_cnt;
        send(rnd256(), 32'hFF00_00FF, 32'hFF00_00FF, 1'b1, 4'h5, 4'h6, 1'b0);
        drain();
        chk("t3_ends_chunks", 128'(fire_cnt - f0), 128'd2);

        // Case 4: all-null beats
        f0 = fire_cnt;
        send(rnd256(), 32'h0, 32'h0, 1'b0, 4'h7, 4'h8, 1'b0);
        drain();
        chk("t4_null_dropped", 128'(fire_cnt - f0), 128'd0);
        f0 = fire_cnt;
        send(rnd256(), 32'h0, 32'h0, 1'b1, 4'h9, 4'hB, 1'b0);
        drain();
        chk("t4_null_last_one_chunk", 128'(fire_cnt - f0), 128'd1);

        // Case 5: corrupted TUSER bit 5
        f0 = fire_cnt;
        send(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'hC, 4'hD, 1'b1);
        chk("t5_perr_pulse", 128'(parity_err), 128'd1);
        chk("t5_err_cnt", 128'(err_cnt), 128'd1);
        @(posedge clk);
        #1;
        chk("t5_perr_one_cycle", 128'(parity_err), 128'd0);
        drain();
        chk("t5_data_delivered", 128'(fire_cnt - f0), 128'd4);

        // Case 6a: stall mid-beat, fields held
        send(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'hE, 4'hF, 1'b0);
        @(posedge clk);
        #1;
        out_if.tready = 1'b0;
        @(negedge clk);
        chk("t6_stall_valid", 128'(out_if.tvalid), 128'd1);
        snap = {out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast, out_if.tuser, out_if.tid, out_if.tdest};
        repeat (5) begin
            @(negedge clk);
            chk("t6_stable", 128'({out_if.tdata, out_if.tkeep, out_if.tstrb, out_if.tlast, out_if.tuser,
                                   out_if.tid, out_if.tdest}), snap);
        end
        @(posedge clk);
        #1;
        out_if.tready = 1'b1;
        drain();

        // Case 6b: reset with two buffered beats
        out_if.tready = 1'b0;
        send(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1, 4'h1, 1'b1);
        send(rnd256(), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h1, 4'h1, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 128'(out_if.tvalid), 128'd0);
        chk("t6_rst_in_ready", 128'(in_if.tready), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_if.tready = 1'b1;
        f0 = fire_cnt;
        repeat (5) @(negedge clk);
        #1;
        chk("t6_no_residue", 128'(fire_cnt - f0), 128'd0);
        chk("t6_err_cnt_cleared", 128'(err_cnt), 128'd0);
        @(posedge clk);
        #1;
        f0 = fire_cnt;
        send(rnd256(), 32'h00FF_FF00, 32'h00FF_FF00, 1'b1, 4'h2, 4'h3, 1'b0);
        drain();
        chk("t6_restart_chunks", 128'(fire_cnt - f0), 128'd2);

        // Case 7: randomized beats with random backpressure
        rand_rdy = 1'b1;
        for (int b = 0; b < 60; b++) begin
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 3))
                    0:       k[8*i +: 8] = 8'h00;
                    2:       k[8*i +: 8] = 8'($urandom);
                    default: k[8*i +: 8] = 8'hFF;
                endcase
            end
            send(rnd256(), k, k & $urandom, ($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 7) == 0));
        end
        drain();
        rand_rdy = 1'b0;
        out_if.tready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
